// File: rtl/usr_pkg.sv
// Shared encodings for the sequenced universal shift register: command ops,
// core select codes, controller states and op-decode helpers.
package usr_pkg;

  typedef enum logic [2:0] {
    OP_NOP      = 3'b000,
    OP_LOAD     = 3'b001,
    OP_SHR      = 3'b010,
    OP_SHL      = 3'b011,
    OP_ROR      = 3'b100,
    OP_ROL      = 3'b101,
    OP_LOAD_SHR = 3'b110,
    OP_LOAD_SHL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'b00,
    SEL_RIGHT = 2'b01,
    SEL_LEFT  = 2'b10,
    SEL_LOAD  = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  function automatic logic op_is_load(input op_e op);
    return (op == OP_LOAD) || (op == OP_LOAD_SHR) || (op == OP_LOAD_SHL);
  endfunction

  // Every op except NOP and plain LOAD moves bits through the register.
  function automatic logic op_shifts(input op_e op);
    return (op != OP_NOP) && (op != OP_LOAD);
  endfunction

  function automatic logic op_is_right(input op_e op);
    return (op == OP_SHR) || (op == OP_ROR) || (op == OP_LOAD_SHR);
  endfunction

endpackage

// File: rtl/usr_core.sv
// WIDTH-bit universal shift register: hold, shift right, shift left or
// parallel load, chosen by a 2-bit select.
module usr_core
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  sel_e             select,
  input  logic             sr,
  input  logic             sl,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  // Register update selected by the controller.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_q <= '0;
    end else begin
      case (select)
        SEL_HOLD:  q_q <= q_q;
        SEL_RIGHT: q_q <= {sr, q_q[WIDTH-1:1]};
        SEL_LEFT:  q_q <= {q_q[WIDTH-2:0], sl};
        SEL_LOAD:  q_q <= pin;
        default:   q_q <= q_q;
      endcase
    end
  end

  assign q = q_q;

endmodule

// File: rtl/usr_seq_ctrl.sv
// Command-driven sequencer around usr_core (load / shift / rotate by count).
// Optional macro USR_SEQ_CTRL_ROTATE_EN makes ROR/ROL true rotates.
module usr_seq_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             fill_q, fill_d;
  logic             done_q, busy_q, ready_q;
  sel_e             select_s;
  logic             sr_s, sl_s;

  // Next-state logic; command fields are captured only on a handshake.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    fill_d  = fill_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d   = op_e'(cmd_op);
          cnt_d  = cmd_cnt;
          data_d = cmd_data;
          fill_d = cmd_fill;
          if (op_is_load(op_e'(cmd_op))) begin
            state_d = ST_LOAD;
          end else if (op_shifts(op_e'(cmd_op)) && (cmd_cnt != '0)) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (op_shifts(op_q) && (cnt_q != '0)) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_DONE;
        end
      end
      // The counter doubles as the latched step count and counts down to 1.
      ST_SHIFT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Core select decoded from the current state.
  always_comb begin
    select_s = SEL_HOLD;
    case (state_q)
      ST_LOAD:  select_s = SEL_LOAD;
      ST_SHIFT: select_s = op_is_right(op_q) ? SEL_RIGHT : SEL_LEFT;
      default:  select_s = SEL_HOLD;
    endcase
  end

  // Serial inputs: rotates feed back the outgoing bit when enabled.
  always_comb begin
`ifdef USR_SEQ_CTRL_ROTATE_EN
    sr_s = (op_q == OP_ROR) ? q[0] : fill_q;
    sl_s = (op_q == OP_ROL) ? q[WIDTH-1] : fill_q;
`else
    sr_s = fill_q;
    sl_s = fill_q;
`endif
  end

  // Controller state and registered status outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      data_q  <= '0;
      fill_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      done_q  <= (state_d == ST_DONE);
      busy_q  <= (state_d != ST_IDLE);
      ready_q <= (state_d == ST_IDLE);
    end
  end

  usr_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .clr_n  (clr_n),
    .select (select_s),
    .sr     (sr_s),
    .sl     (sl_s),
    .pin    (data_q),
    .q      (q)
  );

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/usr_seq_ctrl.md
USR_SEQ_CTRL -- requirements
Module: usr_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 4, shift register width in bits.
REQ-002 Parameter: CNT_W, 4, shift-count field width; counts range 0..2^CNT_W-1.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: clr_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: cmd_valid  input  1  command present.
REQ-006 Port: cmd_ready  output  1  controller idle and accepting; handshake = cmd_valid & cmd_ready at rising edge.
REQ-007 Port: cmd_op  input  3  000 NOP, 001 LOAD, 010 SHR, 011 SHL, 100 ROR, 101 ROL, 110 LOAD_SHR, 111 LOAD_SHL.
REQ-008 Port: cmd_cnt  input  CNT_W  number of shift steps.
REQ-009 Port: cmd_data  input  WIDTH  parallel load value.
REQ-010 Port: cmd_fill  input  1  serial bit shifted in for SHR/SHL.
REQ-011 Port: q  output  WIDTH  current register contents.
REQ-012 Port: busy  output  1  high in every state except IDLE.
REQ-013 Port: done  output  1  one-cycle completion pulse.

Function
REQ-014 Command fields SHALL be latched only on handshake; inputs at other times SHALL be ignored.
REQ-015 FSM states: IDLE, LOAD, SHIFT, DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-016 IDLE + handshake SHALL go to: LOAD for LOAD/LOAD_SHR/LOAD_SHL; SHIFT for shift/rotate ops with cmd_cnt!=0; otherwise DONE.
REQ-017 LOAD SHALL drive select=11 for exactly one cycle (q <= data), then go to SHIFT if op is LOAD_SHR/LOAD_SHL and cnt!=0, else DONE.
REQ-018 SHIFT SHALL perform one step per cycle for exactly cnt cycles via an internal down-counter, then go to DONE.
REQ-019 Right step: q <= {sr, q[WIDTH-1:1]}; left step: q <= {q[WIDTH-2:0], sl}.
REQ-020 SHR/SHL/LOAD_SHR/LOAD_SHL SHALL use sr/sl = latched cmd_fill.
REQ-021 DONE SHALL last one cycle with done=1 and select=00 (hold), then go to IDLE.
REQ-022 q SHALL hold (select=00) in IDLE and DONE; NOP SHALL leave q unchanged.
REQ-023 cnt=0 on a shift/rotate op SHALL produce no step; done SHALL assert on the cycle after the accepting edge.
REQ-024 A cnt greater than WIDTH SHALL be honoured fully (no saturation).
REQ-025 cmd_valid while busy SHALL be ignored, with no queueing.

Reset
REQ-026 clr_n low SHALL immediately force q=0, FSM=IDLE, counter=0, done=0, busy=0, cmd_ready=1, including mid-LOAD or mid-SHIFT.
REQ-027 The first handshake SHALL be accepted on the first rising edge after clr_n deasserts.

Configuration
REQ-028 Macro USR_SEQ_CTRL_ROTATE_EN: when defined, ROR SHALL use sr=q[0] and ROL SHALL use sl=q[WIDTH-1].
REQ-029 When USR_SEQ_CTRL_ROTATE_EN is undefined, ROR/ROL SHALL behave exactly as SHR/SHL using cmd_fill.

Structure
REQ-030 Package usr_pkg SHALL hold the cmd_op encodings, the select encodings (00 hold, 01 right, 10 left, 11 load) and the FSM state typedef.
REQ-031 Sub-module usr_core SHALL implement the WIDTH-bit universal shift register (clk, clr_n, select, serial right/left, parallel in, q); usr_seq_ctrl SHALL instantiate it once.

Verification
REQ-032 Reset test: clr_n=0 -> q=0000, cmd_ready=1, busy=0, done=0.
REQ-033 LOAD test: LOAD data=1010 -> q=1010 one edge after accept; done pulses for exactly one cycle on the following cycle.
REQ-034 SHR test: from q=1010, SHR cnt=2 fill=1 -> q=1101 then 1110; exactly one done pulse; cmd_ready low throughout.
REQ-035 Rotate test: from q=1001, ROL cnt=1 fill=0 -> 0011 with macro defined, 0010 without.
REQ-036 Edge cases: SHL cnt=0 -> q unchanged, done on the next cycle; cmd_valid pulsed while busy -> no effect; LOAD_SHL data=0001 cnt=3 fill=0 -> q=1000.
REQ-037 Reset mid-op: clr_n=0 during SHR cnt=15 -> q=0000 immediately, no done pulse, cmd_ready=1.
